// File: rtl/cache_fill_fsm.sv
// I-cache line fill controller: on a miss it streams 8 words from memory into the data array,
// then writes the line's metadata and holds off one cycle for the cache's registered tag update.
module cache_fill_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Miss,
    input  logic [15:0] Addr_CPU,
    output logic [15:0] Addr_FSM,
    output logic [15:0] DataOut_FSM,
    output logic        Data_WE,
    output logic        MetaData_WE,
    output logic        busy,
    output logic        mem_en,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    input  logic        mem_valid
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StMeta,
        StSettle
    } state_e;

    state_e      state_q;
    logic [11:0] base_q;
    logic [2:0]  issue_q;
    logic [2:0]  recv_q;
    logic        accept;

    // Responses are only meaningful while a fill is collecting words; elsewhere they are strays.
    assign accept = rst_n && mem_valid && ((state_q == StFetch) || (state_q == StWait));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            base_q  <= '0;
            issue_q <= '0;
            recv_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (Miss) begin
                        base_q  <= Addr_CPU[15:4];
                        issue_q <= '0;
                        recv_q  <= '0;
                        state_q <= StFetch;
                    end
                end
                StFetch: begin
                    issue_q <= issue_q + 3'd1;
                    if (issue_q == 3'd7) begin
                        state_q <= StWait;
                    end
                end
                StWait:   ;
                StMeta:   state_q <= StSettle;
                StSettle: state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
            // The last word can land while still issuing; it takes priority over FETCH->WAIT.
            if (accept) begin
                recv_q <= recv_q + 3'd1;
                if (recv_q == 3'd7) begin
                    state_q <= StMeta;
                end
            end
        end
    end

    always_comb begin
        busy        = rst_n && (state_q != StIdle);
        mem_en      = rst_n && (state_q == StFetch);
        mem_addr    = {base_q, issue_q, 1'b0};
        Data_WE     = accept;
        MetaData_WE = rst_n && (state_q == StMeta);
        DataOut_FSM = mem_data;
        unique case (state_q)
            StIdle:  Addr_FSM = Addr_CPU;
            StMeta:  Addr_FSM = {base_q, 4'b0000};
            default: Addr_FSM = {base_q, recv_q, 1'b0};
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: a timeline model of each fill checked every cycle, plus literal
// checks of the request/write/metadata sequences for each directed scenario.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Miss = 1'b0;
    logic [15:0] Addr_CPU = 16'h0;
    logic [15:0] mem_data = 16'h0;
    logic        mem_valid = 1'b0;
    logic [15:0] Addr_FSM, DataOut_FSM, mem_addr;
    logic        Data_WE, MetaData_WE, busy, mem_en;

    cache_fill_fsm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Miss        (Miss),
        .Addr_CPU    (Addr_CPU),
        .Addr_FSM    (Addr_FSM),
        .DataOut_FSM (DataOut_FSM),
        .Data_WE     (Data_WE),
        .MetaData_WE (MetaData_WE),
        .busy        (busy),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_valid   (mem_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] word_data(input logic [15:0] b, input int k);
        return (b ^ 16'hA5A5) + 16'(k * 257);
    endfunction

    // Timeline model: a fill is cycles-since-capture, words-received and cycles-after-last-word.
    bit          m_active = 1'b0;
    logic [15:0] m_base = 16'h0;
    int          m_cyc = 0;
    int          m_got = 0;
    int          m_post = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active <= 1'b0;
        end else if (!m_active) begin
            if (Miss) begin
                m_active <= 1'b1;
                m_base   <= {Addr_CPU[15:4], 4'h0};
                m_cyc    <= 0;
                m_got    <= 0;
                m_post   <= 0;
            end
        end else if (m_got < 8) begin
            m_cyc <= m_cyc + 1;
            if (mem_valid) m_got <= m_got + 1;
        end else if (m_post == 0) begin
            m_post <= 1;
        end else begin
            m_active <= 1'b0;
        end
    end

    logic [15:0] req_q[$];
    logic [15:0] wr_a[$];
    logic [15:0] wr_d[$];
    logic [15:0] meta_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_busy", busy, 0);
            check("rst_mem_en", mem_en, 0);
            check("rst_data_we", Data_WE, 0);
            check("rst_meta_we", MetaData_WE, 0);
        end else if (!m_active) begin
            check("idle_busy", busy, 0);
            check("idle_mem_en", mem_en, 0);
            check("idle_data_we", Data_WE, 0);
            check("idle_meta_we", MetaData_WE, 0);
            check("idle_addr_fsm", Addr_FSM, Addr_CPU);
            check("idle_dout", DataOut_FSM, mem_data);
        end else if (m_got < 8) begin
            check("fill_busy", busy, 1);
            check("fill_mem_en", mem_en, 16'(m_cyc < 8));
            if (m_cyc < 8) check("fill_mem_addr", mem_addr, 16'(m_base + 16'(2 * m_cyc)));
            check("fill_data_we", Data_WE, 16'(mem_valid));
            check("fill_meta_we", MetaData_WE, 0);
            if (mem_valid) begin
                check("fill_addr_fsm", Addr_FSM, 16'(m_base + 16'(2 * m_got)));
                check("fill_dout", DataOut_FSM, mem_data);
            end
        end else if (m_post == 0) begin
            check("meta_busy", busy, 1);
            check("meta_mem_en", mem_en, 0);
            check("meta_data_we", Data_WE, 0);
            check("meta_meta_we", MetaData_WE, 1);
            check("meta_addr_fsm", Addr_FSM, m_base);
        end else begin
            check("settle_busy", busy, 1);
            check("settle_mem_en", mem_en, 0);
            check("settle_data_we", Data_WE, 0);
            check("settle_meta_we", MetaData_WE, 0);
        end
        if (mem_en) req_q.push_back(mem_addr);
        if (Data_WE) begin
            wr_a.push_back(Addr_FSM);
            wr_d.push_back(DataOut_FSM);
        end
        if (MetaData_WE) meta_q.push_back(Addr_FSM);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        req_q.delete();
        wr_a.delete();
        wr_d.delete();
        meta_q.delete();
    endtask

    // first: cycle (0 = first FETCH cycle) of word 0's response; gaps[k]: idle cycles before word k.
    task automatic do_fill(input logic [15:0] a, input int first, input int gaps[8],
                           input bit hold);
        logic [15:0] b;
        int          next_v;
        int          k;
        b = {a[15:4], 4'h0};
        clear_logs();
        Miss      = 1'b1;
        Addr_CPU  = a;
        mem_valid = 1'b0;
        tick();
        if (!hold) Miss = 1'b0;
        Addr_CPU = ~a;
        next_v   = first;
        k        = 0;
        for (int c = 0; k < 8 && c < 200; c++) begin
            if (c == next_v) begin
                mem_valid = 1'b1;
                mem_data  = word_data(b, k);
            end else begin
                mem_valid = 1'b0;
                mem_data  = 16'(16'h1111 * c);
            end
            tick();
            if (c == next_v) begin
                k++;
                if (k < 8) next_v = c + 1 + gaps[k];
            end
        end
        mem_valid = 1'b0;
        tick();
        tick();
        check("log_req_count", 16'(req_q.size()), 16'd8);
        check("log_wr_count", 16'(wr_a.size()), 16'd8);
        check("log_meta_count", 16'(meta_q.size()), 16'd1);
        for (int i = 0; i < 8; i++) begin
            if (i < req_q.size()) check("log_req_addr", req_q[i], 16'(b + 16'(2 * i)));
            if (i < wr_a.size()) begin
                check("log_wr_addr", wr_a[i], 16'(b + 16'(2 * i)));
                check("log_wr_data", wr_d[i], word_data(b, i));
            end
        end
        if (meta_q.size() > 0) check("log_meta_addr", meta_q[0], b);
    endtask

    int g_zero[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int g_irr[8]  = '{0, 2, 5, 0, 1, 4, 3, 0};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with Miss asserted: nothing may start.
        rst_n = 1'b0;
        Miss  = 1'b1;
        Addr_CPU = 16'h5555;
        tick();
        tick();
        @(negedge clk);
        check("lit_in_reset_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        Miss  = 1'b0;
        @(negedge clk);
        check("lit_post_reset_busy", busy, 0);
        check("lit_post_reset_mem_en", mem_en, 0);
        tick();

        // Basic fill, latency 4.
        do_fill(16'h1236, 4, g_zero, 1'b0);
        check("lit_basic_first_req", req_q.size() > 0 ? req_q[0] : 16'hxxxx, 16'h1230);
        check("lit_basic_last_wr", wr_a.size() == 8 ? wr_a[7] : 16'hxxxx, 16'h123E);
        check("lit_basic_meta", meta_q.size() > 0 ? meta_q[0] : 16'hxxxx, 16'h1230);

        // Latency 1, responses overlapping issue.
        do_fill(16'h2F0A, 1, g_zero, 1'b0);
        check("lit_lat1_first_wr", wr_a.size() > 0 ? wr_a[0] : 16'hxxxx, 16'h2F00);

        // Irregular response gaps.
        do_fill(16'h7FF8, 3, g_irr, 1'b0);

        // Top-of-memory line.
        do_fill(16'hFFFE, 3, g_zero, 1'b0);
        check("lit_top_last_req", req_q.size() == 8 ? req_q[7] : 16'hxxxx, 16'hFFFE);

        // Miss held through SETTLE, then a back-to-back fill from IDLE.
        do_fill(16'hABCD, 2, g_zero, 1'b1);
        @(negedge clk);
        check("lit_hold_idle_busy", busy, 0);
        do_fill(16'h0102, 1, g_zero, 1'b0);
        check("lit_hold_new_base", meta_q.size() > 0 ? meta_q[0] : 16'hxxxx, 16'h0100);

        // Reset after the third word while responses keep arriving.
        clear_logs();
        Miss     = 1'b1;
        Addr_CPU = 16'h4A52;
        tick();
        Miss = 1'b0;
        for (int c = 0; c < 5; c++) begin
            mem_valid = (c >= 2);
            mem_data  = word_data(16'h4A50, c - 2);
            tick();
        end
        check("lit_pre_reset_words", 16'(wr_a.size()), 16'd3);
        clear_logs();
        rst_n     = 1'b0;
        mem_valid = 1'b1;
        mem_data  = 16'h3333;
        @(negedge clk);
        check("lit_mid_reset_busy", busy, 0);
        check("lit_mid_reset_data_we", Data_WE, 0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            mem_data = 16'(16'h4440 + c);
            @(negedge clk);
            check("lit_after_reset_data_we", Data_WE, 0);
            check("lit_after_reset_busy", busy, 0);
            tick();
        end
        mem_valid = 1'b0;
        check("lit_after_reset_no_writes", 16'(wr_a.size()), 16'd0);
        do_fill(16'h8000, 2, g_zero, 1'b0);
        check("lit_8000_last_wr", wr_a.size() == 8 ? wr_a[7] : 16'hxxxx, 16'h800E);

        // Stray response in IDLE.
        mem_valid = 1'b1;
        mem_data  = 16'hBEEF;
        @(negedge clk);
        check("lit_stray_data_we", Data_WE, 0);
        check("lit_stray_dout", DataOut_FSM, 16'hBEEF);
        tick();
        mem_valid = 1'b0;
        @(negedge clk);
        check("lit_stray_busy", busy, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 SHALL have no parameters; line size fixed at 8 words of 16 bits, 16-bit byte addressing.
REQ-002 SHALL have a single clock and reset: clk input 1, the only clock; rst_n input 1, reset that is synchronous and active-low.
REQ-003 SHALL have the following ports, one per line: name, direction, width, meaning.
- Miss  input  1  cache miss indication from the I-cache.
- Addr_CPU  input  16  CPU fetch address presented to the cache.
- Addr_FSM  output  16  word address driven to the cache for fill writes.
- DataOut_FSM  output  16  fill data driven to the cache's DataIn_FSM port.
- Data_WE  output  1  cache data-array write enable.
- MetaData_WE  output  1  cache metadata write enable.
- busy  output  1  fill in progress; the CPU front end stalls on it.
- mem_en  output  1  memory read request, one word per cycle.
- mem_addr  output  16  memory read address.
- mem_data  input  16  memory read data.
- mem_valid  input  1  mem_data valid this cycle; responses return in request order at any latency >= 1.

Function
REQ-004 SHALL implement states IDLE, FETCH, WAIT, META, SETTLE.
REQ-005 IDLE: when Miss=1, SHALL latch base = {Addr_CPU[15:4], 4'b0000}, clear both counters, and go to FETCH.
REQ-006 FETCH: SHALL assert mem_en=1 with mem_addr = {base[15:4], issue_cnt, 1'b0}, then increment the 3-bit issue_cnt; after issuing word 7 (8 requests on 8 consecutive cycles), SHALL go to WAIT.
REQ-007 In FETCH and WAIT, each cycle with mem_valid=1 SHALL produce Data_WE=1 combinationally, with DataOut_FSM=mem_data and Addr_FSM = {base[15:4], recv_cnt, 1'b0}; recv_cnt SHALL then increment.
REQ-008 SHALL handle responses that overlap issue: mem_valid may arrive while still in FETCH, and it is accepted per REQ-007.
REQ-009 When mem_valid=1 with recv_cnt=7, SHALL go to META the next cycle, whether the current state is FETCH or WAIT.
REQ-010 META: for exactly one cycle, SHALL drive MetaData_WE=1 and Addr_FSM=base with Data_WE=0, then go to SETTLE.
REQ-011 SETTLE: for one cycle, SHALL ignore Miss to cover the cache's one-cycle registered metadata write, then go to IDLE.
REQ-012 busy SHALL be 1 in every state except IDLE, and 0 in IDLE.
REQ-013 SHALL ignore mem_valid in IDLE, META and SETTLE: Data_WE=0 and no counter change.
REQ-014 SHALL ignore changes to Miss and Addr_CPU outside IDLE; base is held until the next IDLE capture.
REQ-015 In IDLE, Addr_FSM SHALL equal Addr_CPU and DataOut_FSM SHALL equal mem_data; mem_en, Data_WE and MetaData_WE SHALL be 0.
REQ-016 Counter and address arithmetic SHALL be 3-bit wrap within the line; base[15:4] never changes mid-fill.
REQ-017 Data_WE and MetaData_WE SHALL never be 1 in the same cycle.

Reset
REQ-018 On a clk edge with rst_n=0, SHALL enter IDLE and clear base=0, issue_cnt=0 and recv_cnt=0.
REQ-019 While in reset and on the first cycle after it, busy, mem_en, Data_WE and MetaData_WE SHALL all be 0.
REQ-020 Reset mid-fill SHALL abandon the fill; in-flight mem_valid responses after reset SHALL be ignored per REQ-013.

Verification
REQ-021 Basic fill: Miss=1 with Addr_CPU=0x1236, memory latency 4 -> mem_addr sequence 0x1230, 0x1232, ... 0x123E; Data_WE on 8 cycles at Addr_FSM 0x1230..0x123E with matching data; one MetaData_WE cycle with Addr_FSM=0x1230; busy high from the cycle after Miss through SETTLE.
REQ-022 Latency 1: mem_valid overlaps FETCH -> all 8 writes correct, META immediately after the 8th valid, no missed or duplicated words.
REQ-023 Irregular valid: mem_valid gaps of 0-5 cycles -> recv_cnt advances only on valid cycles, exactly 8 Data_WE pulses, then META.
REQ-024 Miss held high through SETTLE -> no new fill starts until IDLE; a Miss in IDLE one cycle later starts a new fill.
REQ-025 Reset after the 3rd returned word, with remaining valids still arriving -> IDLE, outputs 0, no Data_WE; a fresh Miss at 0x8000 fills 0x8000..0x800E correctly.
REQ-026 Stray mem_valid in IDLE with data 0xBEEF -> Data_WE=0, state stays IDLE.
